// File: rtl/ant_world_engine.sv
// Ant-farm world: trail grid plus a Langton's-ant walker, exported as 2-bit pixels.
// In: clk, rst_btn (async, low), run, step_req, clear. Out: pixel_memory, ant_pos, ant_dir, step_count, busy.
module ant_world_engine #(
  parameter int COLS      = 8,
  parameter int ROWS      = 3,
  parameter int TICK_DIV  = 25000000,
  parameter int START_COL = 4,
  parameter int START_ROW = 1,
  localparam int CELLS    = COLS * ROWS,
  localparam int PIW      = $clog2(CELLS)
) (
  input  logic               clk,
  input  logic               rst_btn,
  input  logic               run,
  input  logic               step_req,
  input  logic               clear,
  output logic [2*CELLS-1:0] pixel_memory,
  output logic [PIW-1:0]     ant_pos,
  output logic [1:0]         ant_dir,
  output logic [15:0]        step_count,
  output logic               busy
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(TICK_DIV);

  localparam logic [CW-1:0]  COL0 = CW'(START_COL);
  localparam logic [RW-1:0]  ROW0 = RW'(START_ROW);
  localparam logic [PIW-1:0] POS0 = PIW'(START_ROW * COLS + START_COL);
  localparam logic [CW-1:0]  CMAX = CW'(COLS - 1);
  localparam logic [RW-1:0]  RMAX = RW'(ROWS - 1);
  localparam logic [PW-1:0]  PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    FLIP,
    MOVE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       dir_q;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic [PIW-1:0]   pos_q;
  logic [CELLS-1:0] trail_q;
  logic [15:0]      cnt_q;
  logic [PW-1:0]    pre_q;

  logic             tick;
  logic             trig;
  logic [CW-1:0]    col_n;
  logic [RW-1:0]    row_n;
  logic [PIW-1:0]   pos_n;

  assign tick = run && (pre_q == PMAX);
  assign trig = tick | step_req;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trig) state_d = TURN;
      TURN:    state_d = FLIP;
      FLIP:    state_d = MOVE;
      MOVE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // dir_q already holds the turned heading when MOVE is reached
  always_comb begin
    col_n = col_q;
    row_n = row_q;
    unique case (dir_q)
      2'd0: row_n = (row_q == '0) ? RMAX : row_q - RW'(1);
      2'd1: col_n = (col_q == CMAX) ? '0 : col_q + CW'(1);
      2'd2: row_n = (row_q == RMAX) ? '0 : row_q + RW'(1);
      default: col_n = (col_q == '0) ? CMAX : col_q - CW'(1);
    endcase
    pos_n = PIW'(row_n) * PIW'(COLS) + PIW'(col_n);
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q <= IDLE;
      dir_q   <= 2'd0;
      col_q   <= COL0;
      row_q   <= ROW0;
      pos_q   <= POS0;
      trail_q <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      dir_q   <= 2'd0;
      col_q   <= COL0;
      row_q   <= ROW0;
      pos_q   <= POS0;
      trail_q <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      if (run) pre_q <= tick ? '0 : pre_q + PW'(1);
      unique case (state_q)
        TURN: dir_q <= trail_q[pos_q] ? dir_q - 2'd1
                                      : dir_q + 2'd1;
        FLIP: trail_q[pos_q] <= ~trail_q[pos_q];
        MOVE: begin
          col_q <= col_n;
          row_q <= row_n;
          pos_q <= pos_n;
          cnt_q <= cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < CELLS; i++) begin : g_pix
    assign pixel_memory[2*i]   = trail_q[i];
    assign pixel_memory[2*i+1] = (pos_q == PIW'(i));
  end

  assign ant_pos    = pos_q;
  assign ant_dir    = dir_q;
  assign step_count = cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ant_world_engine.sv
// Bench for ant_world_engine: grid-level walker model plus directed vectors.
// Two instances (default start, corner start) share the same stimulus.
module tb_ant_world_engine;

  localparam int COLS = 8;
  localparam int ROWS = 3;
  localparam int TD   = 8;

  logic        clk;
  logic        rst_btn;
  logic        run;
  logic        step_req;
  logic        clear;
  logic [47:0] pm0, pm1;
  logic [4:0]  ap0, ap1;
  logic [1:0]  ad0, ad1;
  logic [15:0] sc0, sc1;
  logic        bz0, bz1;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 0;

  ant_world_engine #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_btn(rst_btn), .run(run),
    .step_req(step_req), .clear(clear),
    .pixel_memory(pm0), .ant_pos(ap0), .ant_dir(ad0),
    .step_count(sc0), .busy(bz0)
  );

  ant_world_engine #(
    .TICK_DIV(TD), .START_COL(7), .START_ROW(0)
  ) dut2 (
    .clk(clk), .rst_btn(rst_btn), .run(run),
    .step_req(step_req), .clear(clear),
    .pixel_memory(pm1), .ant_pos(ap1), .ant_dir(ad1),
    .step_count(sc1), .busy(bz1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // model: per-instance ant position (col,row), heading, trail grid
  int scol[2] = '{4, 7};
  int srow[2] = '{1, 0};
  int mcol[2], mrow[2], mdir[2], mcnt[2], mph[2];
  int pdir[2], pcol[2], prow[2];
  bit mtr[2][COLS*ROWS];
  int mpre;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcol[k] = scol[k];
      mrow[k] = srow[k];
      mdir[k] = 0;
      mcnt[k] = 0;
      mph[k]  = 0;
      for (int i = 0; i < COLS*ROWS; i++) mtr[k][i] = 0;
    end
    mpre = 0;
  endtask

  // a step is fully worked out when accepted, then revealed:
  // heading one edge later, trail the next, position the next
  task automatic model_edge();
    bit tick;
    int p;
    tick = run && (mpre == TD - 1);
    if (run) mpre = tick ? 0 : mpre + 1;
    for (int k = 0; k < 2; k++) begin
      p = mrow[k] * COLS + mcol[k];
      case (mph[k])
        0: if (tick || step_req) begin
          pdir[k] = mtr[k][p] ? (mdir[k] + 3) % 4
                              : (mdir[k] + 1) % 4;
          pcol[k] = mcol[k];
          prow[k] = mrow[k];
          case (pdir[k])
            0: prow[k] = (prow[k] + ROWS - 1) % ROWS;
            1: pcol[k] = (pcol[k] + 1) % COLS;
            2: prow[k] = (prow[k] + 1) % ROWS;
            default: pcol[k] = (pcol[k] + COLS - 1) % COLS;
          endcase
          mph[k] = 1;
        end
        1: begin
          mdir[k] = pdir[k];
          mph[k]  = 2;
        end
        2: begin
          mtr[k][p] = !mtr[k][p];
          mph[k]    = 3;
        end
        default: begin
          mcol[k] = pcol[k];
          mrow[k] = prow[k];
          mcnt[k] = (mcnt[k] + 1) % 65536;
          mph[k]  = 0;
        end
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_btn);
      if (!rst_btn || clear) model_reset();
      else model_edge();
    end
  end

  function automatic logic [47:0] exp_pix(int k);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < COLS*ROWS; i++) begin
      r[2*i]   = mtr[k][i];
      r[2*i+1] = (i == mrow[k] * COLS + mcol[k]);
    end
    return r;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    else
      n_pass++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("m_pix0", pm0, exp_pix(0));
        check("m_pos0", ap0, mrow[0]*COLS + mcol[0]);
        check("m_dir0", ad0, mdir[0]);
        check("m_cnt0", sc0, mcnt[0]);
        check("m_bsy0", bz0, mph[0] != 0);
        check("m_pix1", pm1, exp_pix(1));
        check("m_pos1", ap1, mrow[1]*COLS + mcol[1]);
        check("m_dir1", ad1, mdir[1]);
        check("m_cnt1", sc1, mcnt[1]);
        check("m_bsy1", bz1, mph[1] != 0);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bz0 && n < 8);
    check("idle_wait", bz0, 0);
  endtask

  task automatic step_once();
    @(negedge clk);
    step_req = 1;
    @(negedge clk);
    step_req = 0;
    wait_idle();
  endtask

  initial begin
    rst_btn  = 0;
    run      = 0;
    step_req = 0;
    clear    = 0;
    repeat (2) @(negedge clk);
    cmp_en = 1;
    check("rst_pix", pm0, 48'h000002000000);
    check("rst_pos", ap0, 12);
    check("rst_dir", ad0, 0);
    check("rst_cnt", sc0, 0);
    check("rst_bsy", bz0, 0);
    check("rst_pix2", pm1, 48'h000000008000);
    @(negedge clk);
    rst_btn = 1;

    // first step, phase by phase
    @(negedge clk);
    step_req = 1;
    @(negedge clk);
    step_req = 0;
    check("s1_bsy_a", bz0, 1);
    check("s1_dir_a", ad0, 0);
    @(negedge clk);
    check("s1_dir_b", ad0, 1);
    check("s1_pix_b", pm0, 48'h000002000000);
    @(negedge clk);
    check("s1_pix_c", pm0, 48'h000003000000);
    check("s1_bsy_c", bz0, 1);
    @(negedge clk);
    check("s1_pix_d", pm0, 48'h000009000000);
    check("s1_pos_d", ap0, 13);
    check("s1_cnt_d", sc0, 1);
    check("s1_bsy_d", bz0, 0);
    check("s1_pix2", pm1, 48'h000000004002);
    check("s1_pos2", ap1, 0);
    check("s1_dir2", ad1, 1);

    repeat (3) step_once();
    check("s4_pix", pm0, 48'h050007000000);
    check("s4_pos", ap0, 12);
    check("s4_dir", ad0, 0);
    check("s4_cnt", sc0, 4);

    step_once();
    check("s5_dir", ad0, 3);
    check("s5_pos", ap0, 11);
    check("s5_pix", pm0, 48'h050004800000);

    // second request lands while busy and is dropped
    @(negedge clk);
    step_req = 1;
    @(negedge clk);
    step_req = 1;
    @(negedge clk);
    step_req = 0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("drop_cnt", sc0, 6);

    // prescaler-paced run
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    check("clr_cnt", sc0, 0);
    check("clr_pix", pm0, 48'h000002000000);
    run = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 8) begin
        check("run_bsy", bz0, 1);
        step_req = 1;
      end
      if (i == 9) step_req = 0;
    end
    run = 0;
    repeat (5) @(negedge clk);
    check("run_cnt", sc0, 5);
    check("run_bsy_end", bz0, 0);

    // clear while in TURN
    @(negedge clk);
    step_req = 1;
    @(negedge clk);
    step_req = 0;
    clear    = 1;
    check("turn_bsy", bz0, 1);
    @(negedge clk);
    clear = 0;
    check("ct_bsy", bz0, 0);
    check("ct_cnt", sc0, 0);
    check("ct_pix", pm0, 48'h000002000000);

    // clear beats a same-cycle trigger
    @(negedge clk);
    clear    = 1;
    step_req = 1;
    @(negedge clk);
    clear    = 0;
    step_req = 0;
    check("cs_bsy", bz0, 0);
    @(negedge clk);
    check("cs_cnt", sc0, 0);

    // async reset while in FLIP
    step_once();
    @(negedge clk);
    step_req = 1;
    @(negedge clk);
    step_req = 0;
    @(negedge clk);
    check("flip_bsy", bz0, 1);
    #2 rst_btn = 0;
    #1;
    check("ar_pix", pm0, 48'h000002000000);
    check("ar_pos", ap0, 12);
    check("ar_dir", ad0, 0);
    check("ar_cnt", sc0, 0);
    check("ar_bsy", bz0, 0);
    check("ar_pix2", pm1, 48'h000000008000);
    @(negedge clk);
    rst_btn = 1;
    repeat (2) @(negedge clk);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
